// File: rtl/tile_read_collector_pkg.sv
// Shared defaults for the tile fetch and collect stages.
// Also holds the word counter width helper.
package tile_read_collector_pkg;

  localparam int DATA_WIDTH_DEF   = 256;
  localparam int NUM_FETCHES_DEF  = 2;
  localparam int READ_LATENCY_DEF = 1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_read_collector_rd_valid_delay.sv
// Delays the BRAM read strobe so it lines up with returning read data.
// busy flags any strobe still travelling through the line.
module rd_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic busy
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = '0;
    if (!clr) begin
      sr_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];
  assign busy = |sr_q;

endmodule

// File: rtl/tile_read_collector.sv
// Assembles BRAM read words into whole tiles using two ping-pong buffers.
// Tiles are presented from registered state only.
module tile_read_collector
  import tile_read_collector_pkg::*;
#(
  parameter int NUM_FETCHES_PER_TILE = NUM_FETCHES_DEF,
  parameter int DATA_WIDTH           = DATA_WIDTH_DEF,
  parameter int READ_LATENCY         = READ_LATENCY_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       bram_en,
  input  logic [DATA_WIDTH-1:0]                      bram_rdata,
  input  logic                                       flush,
  output logic [NUM_FETCHES_PER_TILE*DATA_WIDTH-1:0] tile_data,
  output logic                                       tile_valid,
  input  logic                                       tile_ready,
  output logic                                       space_avail,
  output logic                                       overflow_err
);

  localparam int N  = NUM_FETCHES_PER_TILE;
  localparam int DW = DATA_WIDTH;
  localparam int TW = N * DW;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          rd_valid;
  logic          pending;
  logic [TW-1:0] buf_q [2];
  logic [TW-1:0] buf_d [2];
  logic [1:0]    full_q, full_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  rd_valid_delay #(
    .DEPTH (READ_LATENCY)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .din   (bram_en),
    .dout  (rd_valid),
    .busy  (pending)
  );

  assign accept = full_q[rd_ptr_q] & tile_ready;

  // accept and write never hit the same buffer: one needs full, the other not
  always_comb begin
    buf_d      = buf_q;
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    if (flush) begin
      full_d     = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      word_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (accept) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
      end
      if (rd_valid) begin
        if (full_q[wr_ptr_q]) begin
          ovf_d = 1'b1;
        end else begin
          buf_d[wr_ptr_q][int'(word_cnt_q)*DW +: DW] = bram_rdata;
          if (word_cnt_q == LAST) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
            word_cnt_d       = '0;
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tile_valid   = full_q[rd_ptr_q];
  assign tile_data    = buf_q[rd_ptr_q];
  assign overflow_err = ovf_q;
  assign space_avail  = !full_q[wr_ptr_q] && (word_cnt_q == '0)
                        && !pending && !bram_en;

endmodule

// File: tb/tb_tile_read_collector.sv
// Directed bench: one collector at read latency 1, one at latency 2,
// sharing clock and stimulus.
module tb_tile_read_collector;

  localparam int DW = 16;
  localparam int N  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bram_en;
  logic [DW-1:0] bram_rdata;
  logic          flush;
  logic          tile_ready;

  logic [N*DW-1:0] data1, data2;
  logic            valid1, valid2;
  logic            space1, space2;
  logic            ovf1, ovf2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  tile_read_collector #(
    .NUM_FETCHES_PER_TILE (N),
    .DATA_WIDTH           (DW),
    .READ_LATENCY         (1)
  ) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bram_en      (bram_en),
    .bram_rdata   (bram_rdata),
    .flush        (flush),
    .tile_data    (data1),
    .tile_valid   (valid1),
    .tile_ready   (tile_ready),
    .space_avail  (space1),
    .overflow_err (ovf1)
  );

  tile_read_collector #(
    .NUM_FETCHES_PER_TILE (N),
    .DATA_WIDTH           (DW),
    .READ_LATENCY         (2)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bram_en      (bram_en),
    .bram_rdata   (bram_rdata),
    .flush        (flush),
    .tile_data    (data2),
    .tile_valid   (valid2),
    .tile_ready   (tile_ready),
    .space_avail  (space2),
    .overflow_err (ovf2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic en, input logic [DW-1:0] d);
    bram_en    = en;
    bram_rdata = d;
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    bram_en    = 1'b0;
    bram_rdata = '0;
    flush      = 1'b0;
    tile_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(valid1), 64'd0);
    chk("rst_data",  64'(data1),  64'd0);
    chk("rst_ovf",   64'(ovf1),   64'd0);
    chk("rst_space", 64'(space1), 64'd1);
    rst_n = 1'b1;

    // basic two-word tile
    cyc(1'b1, 16'h0);
    cyc(1'b1, 16'hA);
    cyc(1'b0, 16'hB);
    chk("basic_valid", 64'(valid1), 64'd1);
    chk("basic_data",  64'(data1),  64'h000B_000A);
    chk("basic_space", 64'(space1), 64'd1);
    tile_ready = 1'b1;
    cyc(1'b0, 16'h0);
    chk("basic_taken", 64'(valid1), 64'd0);
    tile_ready = 1'b0;

    // three tiles with no consumer
    cyc(1'b1, 16'h0);
    cyc(1'b1, 16'h1);
    cyc(1'b1, 16'h2);
    cyc(1'b1, 16'h3);
    cyc(1'b1, 16'h4);
    cyc(1'b1, 16'h5);
    cyc(1'b0, 16'h6);
    chk("ovf_valid", 64'(valid1), 64'd1);
    chk("ovf_data0", 64'(data1),  64'h0002_0001);
    chk("ovf_flag",  64'(ovf1),   64'd1);
    chk("ovf_space", 64'(space1), 64'd0);
    tile_ready = 1'b1;
    cyc(1'b0, 16'h0);
    chk("ovf_valid1", 64'(valid1), 64'd1);
    chk("ovf_data1",  64'(data1),  64'h0004_0003);
    cyc(1'b0, 16'h0);
    chk("ovf_empty",  64'(valid1), 64'd0);
    chk("ovf_sticky", 64'(ovf1),   64'd1);
    chk("ovf_space2", 64'(space1), 64'd1);

    // streaming with consumer always ready
    for (int i = 0; i <= 8; i++) begin
      cyc(i < 8, (i >= 1) ? DW'(16'h10 + i - 1) : '0);
      if (i >= 1) begin
        chk("strm_valid", 64'(valid1), 64'((i - 1) % 2));
        if ((i - 1) % 2 == 1)
          chk("strm_data", 64'(data1),
              {32'd0, DW'(16'h10 + i - 1), DW'(16'h10 + i - 2)});
      end
    end
    cyc(1'b0, 16'h0);
    chk("strm_idle", 64'(valid1), 64'd0);

    // accept one buffer as the other completes
    tile_ready = 1'b0;
    cyc(1'b1, 16'h0);
    cyc(1'b1, 16'h21);
    cyc(1'b1, 16'h22);
    chk("pp_valid0", 64'(valid1), 64'd1);
    chk("pp_data0",  64'(data1),  64'h0022_0021);
    cyc(1'b1, 16'h23);
    chk("pp_hold",   64'(data1),  64'h0022_0021);
    tile_ready = 1'b1;
    cyc(1'b0, 16'h24);
    chk("pp_valid1", 64'(valid1), 64'd1);
    chk("pp_data1",  64'(data1),  64'h0024_0023);
    cyc(1'b0, 16'h0);
    chk("pp_empty",  64'(valid1), 64'd0);
    tile_ready = 1'b0;

    // flush clears sticky overflow and in-flight reads
    flush = 1'b1;
    cyc(1'b0, 16'h0);
    chk("fl_ovf1",   64'(ovf1),   64'd0);
    chk("fl_valid2", 64'(valid2), 64'd0);
    flush = 1'b0;
    cyc(1'b1, 16'h0);
    cyc(1'b1, 16'h0);
    cyc(1'b0, 16'h31);
    chk("fl_partial", 64'(space2), 64'd0);
    flush = 1'b1;
    cyc(1'b0, 16'h32);
    chk("fl_valid",  64'(valid2), 64'd0);
    chk("fl_space",  64'(space2), 64'd1);
    chk("fl_ovf2",   64'(ovf2),   64'd0);
    flush = 1'b0;
    cyc(1'b1, 16'h0);
    cyc(1'b1, 16'h0);
    cyc(1'b0, 16'h41);
    cyc(1'b0, 16'h42);
    chk("fl_after_v", 64'(valid2), 64'd1);
    chk("fl_after_d", 64'(data2),  64'h0042_0041);

    // asynchronous reset mid-tile
    cyc(1'b1, 16'h0);
    cyc(1'b1, 16'h51);
    bram_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(valid1), 64'd0);
    chk("ar_data",  64'(data1),  64'd0);
    chk("ar_ovf",   64'(ovf1),   64'd0);
    chk("ar_space", 64'(space1), 64'd1);
    chk("ar_data2", 64'(data2),  64'd0);
    #2;
    rst_n = 1'b1;
    step();
    cyc(1'b1, 16'h0);
    cyc(1'b1, 16'h61);
    chk("ar_half",  64'(valid1), 64'd0);
    cyc(1'b0, 16'h62);
    chk("ar_tile_v", 64'(valid1), 64'd1);
    chk("ar_tile_d", 64'(data1),  64'h0062_0061);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
